// File: rtl/qn_tdc_pkg.sv
// Shared types and constants for the drift-time capture stage.
// Channel numbering: ch = 8*g + k, g = {3A, 3B, 4A, 4B}.
package qn_tdc_pkg;

  localparam int unsigned NUM_CH     = 32;
  localparam int unsigned CH_W       = 5;
  localparam int unsigned TIME_W     = 8;
  localparam int unsigned NAME_W     = 8;
  localparam int unsigned WORD_W     = TIME_W + NAME_W;
  localparam int unsigned SYNC_DEPTH = 2;

  localparam logic [WORD_W-1:0] TRAILER_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SCAN,
    ST_TRAILER,
    ST_HOLDOFF
  } state_t;

  typedef struct packed {
    logic [TIME_W-1:0] drift_time;
    logic [NAME_W-1:0] tube_name;
  } word_t;

  // Tube name: [7:5] index within group, [4] B-layer, [3:0] tube number (3 or 4).
  function automatic logic [NAME_W-1:0] name(input logic [CH_W-1:0] ch);
    logic [3:0] tube_id;
    tube_id = ch[4] ? 4'd4 : 4'd3;
    return {ch[2:0], ch[3], tube_id};
  endfunction

endpackage

// File: rtl/drift_channel.sv
// One drift-tube channel: synchronizer, rising-edge detect and first-hit time latch.
module drift_channel
  import qn_tdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tube,
  input  logic              arm,
  input  logic              clear,
  input  logic [TIME_W-1:0] cntr,
  output logic              hit,
  output logic [TIME_W-1:0] hit_time,
  output logic              take_c
);

  logic [SYNC_DEPTH-1:0] sync;
  logic                  prev;
  logic                  rise;

  // Synchronizer and previous-value register run continuously so a line
  // already high at arm time produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], tube};
      prev <= sync[SYNC_DEPTH-1];
    end
  end

  assign rise   = sync[SYNC_DEPTH-1] & ~prev;
  assign take_c = arm & rise & ~hit;

  // Only the first edge of an event is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit      <= 1'b0;
      hit_time <= '0;
    end else if (clear) begin
      hit      <= 1'b0;
      hit_time <= '0;
    end else if (take_c) begin
      hit      <= 1'b1;
      hit_time <= cntr;
    end
  end

endmodule

// File: rtl/drift_time_capture.sv
// 32-channel drift-time digitizer: arms on a scintillator coincidence, timestamps
// the first edge per tube, then streams {time, name} words and a trailer over valid/ready.
module drift_time_capture
  import qn_tdc_pkg::*;
#(
  parameter int unsigned WINDOW   = 255,
  parameter int unsigned HOLDOFF  = 11,
  parameter bit          EMIT_ALL = 1'b0
) (
  input  logic               clk50,
  input  logic               CLR_N,
  input  logic               SCIN_COIN,
  input  logic [NUM_CH-1:0]  TUBE,
  output logic [WORD_W-1:0]  OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               BUSY,
  output logic [7:0]         OVERRUN
);

  state_t              state;
  state_t              state_n;
  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     ptr_n;
  logic [TIME_W-1:0]   cntr;
  logic [TIME_W-1:0]   cntr_n;
  logic [TIME_W-1:0]   hold_cnt;
  logic [TIME_W-1:0]   hold_cnt_n;

  logic [SYNC_DEPTH-1:0] coin_sync;
  logic                  coin_prev;
  logic                  coin_rise;

  logic [NUM_CH-1:0]   hit;
  logic [NUM_CH-1:0]   take;
  logic [TIME_W-1:0]   hit_time [NUM_CH];
  logic                arm;
  logic                clear;

  logic                look_hit;
  logic [TIME_W-1:0]   look_time;
  logic                valid_n;
  word_t               word_n;
  word_t               out_word;
  logic                out_valid;
  logic                busy;
  logic [7:0]          overrun;

  assign arm   = (state == ST_ARMED);
  assign clear = (state == ST_HOLDOFF);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    drift_channel u_ch (
      .clk      (clk50),
      .rst_n    (CLR_N),
      .tube     (TUBE[i]),
      .arm      (arm),
      .clear    (clear),
      .cntr     (cntr),
      .hit      (hit[i]),
      .hit_time (hit_time[i]),
      .take_c   (take[i])
    );
  end

  // Coincidence path matches the channel path so drift times carry no offset.
  always_ff @(posedge clk50 or negedge CLR_N) begin
    if (!CLR_N) begin
      coin_sync <= '0;
      coin_prev <= 1'b0;
    end else begin
      coin_sync <= {coin_sync[SYNC_DEPTH-2:0], SCIN_COIN};
      coin_prev <= coin_sync[SYNC_DEPTH-1];
    end
  end

  assign coin_rise = coin_sync[SYNC_DEPTH-1] & ~coin_prev;

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cntr_n     = cntr;
    hold_cnt_n = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (coin_rise) begin
          state_n = ST_ARMED;
          cntr_n  = TIME_W'(1);
        end
      end
      ST_ARMED: begin
        cntr_n = cntr + TIME_W'(1);
        if (cntr == TIME_W'(WINDOW)) begin
          state_n = ST_SCAN;
          ptr_n   = '0;
        end
      end
      ST_SCAN: begin
        if (!out_valid || OUT_READY) begin
          if (ptr == CH_W'(NUM_CH - 1)) begin
            state_n = ST_TRAILER;
          end else begin
            ptr_n = ptr + CH_W'(1);
          end
        end
      end
      ST_TRAILER: begin
        if (out_valid && OUT_READY) begin
          state_n    = ST_HOLDOFF;
          hold_cnt_n = TIME_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt >= TIME_W'(HOLDOFF)) begin
          state_n = ST_IDLE;
        end else begin
          hold_cnt_n = hold_cnt + TIME_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output word is registered from the next-state view; a channel captured in
  // the final ARMED cycle is folded in through its take strobe.
  always_comb begin
    look_hit  = hit[ptr_n];
    look_time = hit_time[ptr_n];
    if (take[ptr_n]) begin
      look_hit  = 1'b1;
      look_time = cntr;
    end
    valid_n = (state_n == ST_TRAILER) ||
              ((state_n == ST_SCAN) && (look_hit || EMIT_ALL));
    word_n  = '0;
    if (state_n == ST_TRAILER) begin
      word_n = TRAILER_WORD;
    end else if (valid_n) begin
      word_n.drift_time = look_time;
      word_n.tube_name  = name(ptr_n);
    end
  end

  always_ff @(posedge clk50 or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cntr      <= '0;
      hold_cnt  <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cntr      <= cntr_n;
      hold_cnt  <= hold_cnt_n;
      out_valid <= valid_n;
      out_word  <= word_n;
      busy      <= (state_n != ST_IDLE);
    end
  end

  // Coincidences arriving while an event is in progress are counted, not queued.
  always_ff @(posedge clk50 or negedge CLR_N) begin
    if (!CLR_N) begin
      overrun <= '0;
    end else if (coin_rise && (state != ST_IDLE) && (overrun != 8'hFF)) begin
      overrun <= overrun + 8'd1;
    end
  end

  assign OUT_DATA  = out_word;
  assign OUT_VALID = out_valid;
  assign BUSY      = busy;
  assign OVERRUN   = overrun;

endmodule

// File: tb/tb_drift_time_capture.sv
// Directed bench for drift_time_capture: event words, boundaries, back-pressure,
// overrun counting and mid-event reset, with hand-computed expected words.
module tb_drift_time_capture;

  logic        clk50;
  logic        clr_n;
  logic        coin;
  logic        coin2;
  logic [31:0] tube;
  logic [31:0] tube2;
  logic [15:0] data;
  logic [15:0] data2;
  logic        valid;
  logic        valid2;
  logic        ready;
  logic        ready2;
  logic        busy;
  logic        busy2;
  logic [7:0]  overrun;
  logic [7:0]  overrun2;

  int n_checks = 0;
  int n_errors = 0;
  int busy_total = 0;
  logic [15:0] wq[$];
  logic [15:0] q2[$];
  logic [15:0] exp_q[$];
  logic [7:0]  grp_code [4] = '{8'h03, 8'h13, 8'h04, 8'h14};

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  drift_time_capture #(.WINDOW(64), .HOLDOFF(11), .EMIT_ALL(1'b0)) dut (
    .clk50     (clk50),
    .CLR_N     (clr_n),
    .SCIN_COIN (coin),
    .TUBE      (tube),
    .OUT_DATA  (data),
    .OUT_VALID (valid),
    .OUT_READY (ready),
    .BUSY      (busy),
    .OVERRUN   (overrun)
  );

  drift_time_capture #(.WINDOW(64), .HOLDOFF(11), .EMIT_ALL(1'b1)) dut_all (
    .clk50     (clk50),
    .CLR_N     (clr_n),
    .SCIN_COIN (coin2),
    .TUBE      (tube2),
    .OUT_DATA  (data2),
    .OUT_VALID (valid2),
    .OUT_READY (ready2),
    .BUSY      (busy2),
    .OVERRUN   (overrun2)
  );

  // Accepted words are logged on the falling edge, clear of the active edge.
  always @(negedge clk50) begin
    if (valid && ready) wq.push_back(data);
    if (valid2 && ready2) q2.push_back(data2);
    if (busy) busy_total++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #2;
  endtask

  function automatic logic [15:0] word_at(input int idx);
    if (idx < wq.size()) return wq[idx];
    return 16'hDEAD;
  endfunction

  task automatic check_words(input string tag, input int base);
    check({tag, "_count"}, 32'(wq.size() - base), 32'(exp_q.size()));
    foreach (exp_q[i])
      check($sformatf("%s_w%0d", tag, i), 32'(word_at(base + i)), 32'(exp_q[i]));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  initial begin
    int base;
    int b0;
    int n;
    logic [7:0] nm;

    clr_n  = 1'b0;
    coin   = 1'b0;
    coin2  = 1'b0;
    tube   = '0;
    tube2  = '0;
    ready  = 1'b1;
    ready2 = 1'b1;
    tick();
    tick();
    check("rst_valid",   32'(valid),   32'd0);
    check("rst_data",    32'(data),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_valid2",  32'(valid2),  32'd0);
    clr_n = 1'b1;
    tick();

    // Basic event: tube 3A0 at +10, 4B7 at +40.
    base = wq.size();
    b0   = busy_total;
    for (int t = 0; t < 50; t++) begin
      coin     = (t < 2);
      tube[0]  = (t >= 10 && t < 12);
      tube[31] = (t >= 40 && t < 42);
      tick();
    end
    wait_idle("t1", 300);
    exp_q = '{16'h0A03, 16'h28F4, 16'hFFFF};
    check_words("t1", base);
    check("t1_busy_len", 32'(busy_total - b0), 32'd108);
    check("t1_overrun", 32'(overrun), 32'd0);

    // Empty event: trailer only.
    base = wq.size();
    for (int t = 0; t < 4; t++) begin
      coin = (t < 2);
      tick();
    end
    wait_idle("t2", 300);
    exp_q = '{16'hFFFF};
    check_words("t2", base);

    // Emit-all instance: every channel with time 0, then the trailer.
    base = q2.size();
    for (int t = 0; t < 4; t++) begin
      coin2 = (t < 2);
      tick();
    end
    n = 0;
    while (busy2 && n < 300) begin
      tick();
      n++;
    end
    check("t2all_idle", 32'(busy2), 32'd0);
    check("t2all_count", 32'(q2.size() - base), 32'd33);
    for (int i = 0; i < 32; i++) begin
      nm = grp_code[i / 8] | 8'((i % 8) * 32);
      check($sformatf("t2all_w%0d", i),
            32'((base + i < q2.size()) ? q2[base + i] : 16'hDEAD), 32'({8'h00, nm}));
    end
    check("t2all_trailer", 32'((base + 32 < q2.size()) ? q2[base + 32] : 16'hDEAD), 32'hFFFF);

    // Double pulse, line high at arm, edge with the coincidence, edges at and past the window end.
    tube[6] = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    base = wq.size();
    for (int t = 0; t < 70; t++) begin
      coin     = (t < 2);
      tube[0]  = (t < 2) || (t >= 64 && t < 66);
      tube[5]  = (t >= 7 && t < 9) || (t >= 20 && t < 22);
      tube[6]  = (t < 25) || (t >= 30 && t < 32);
      tube[30] = (t >= 65 && t < 67);
      tube[31] = (t >= 64 && t < 66);
      tick();
    end
    tube = '0;
    wait_idle("t3", 300);
    exp_q = '{16'h4003, 16'h07A3, 16'h1EC3, 16'h40F4, 16'hFFFF};
    check_words("t3", base);

    // Back-pressure on the first word, then back-to-back drain.
    base  = wq.size();
    ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      coin    = (t < 2);
      tube[2] = (t >= 12 && t < 14);
      tube[3] = (t >= 13 && t < 15);
      tick();
    end
    tube = '0;
    wait_valid("t4", 200);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t4_stall%0d", s), 32'({valid, data}), 32'({1'b1, 16'h0C43}));
      tick();
    end
    ready = 1'b1;
    tick();
    check("t4_next", 32'({valid, data}), 32'({1'b1, 16'h0D63}));
    wait_idle("t4", 300);
    exp_q = '{16'h0C43, 16'h0D63, 16'hFFFF};
    check_words("t4", base);

    // Coincidences during ARMED and HOLDOFF are dropped and counted.
    base = wq.size();
    b0   = busy_total;
    for (int t = 0; t < 110; t++) begin
      coin    = (t < 2) || (t >= 30 && t < 32) || (t >= 101 && t < 103);
      tube[1] = (t >= 15 && t < 17);
      tick();
    end
    tube = '0;
    coin = 1'b0;
    wait_idle("t5", 300);
    exp_q = '{16'h0F23, 16'hFFFF};
    check_words("t5", base);
    check("t5_busy_len", 32'(busy_total - b0), 32'd108);
    check("t5_overrun", 32'(overrun), 32'd2);

    // Flood of coincidences saturates the counter.
    for (int t = 0; t < 1600; t++) begin
      coin = ((t % 4) < 2);
      tick();
    end
    coin = 1'b0;
    wait_idle("t5sat", 300);
    check("t5_overrun_sat", 32'(overrun), 32'd255);

    // Reset while a word is pending in SCAN.
    ready = 1'b0;
    for (int t = 0; t < 15; t++) begin
      coin    = (t < 2);
      tube[4] = (t >= 5 && t < 7);
      tube[7] = (t >= 9 && t < 11);
      tick();
    end
    tube = '0;
    wait_valid("t6", 200);
    check("t6_word", 32'(data), 32'h0583);
    clr_n = 1'b0;
    #1;
    check("t6_rst_valid",   32'(valid),   32'd0);
    check("t6_rst_busy",    32'(busy),    32'd0);
    check("t6_rst_data",    32'(data),    32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    clr_n = 1'b1;
    ready = 1'b1;
    tick();
    base = wq.size();
    for (int t = 0; t < 30; t++) begin
      coin    = (t < 2);
      tube[8] = (t >= 20 && t < 22);
      tick();
    end
    tube = '0;
    wait_idle("t6b", 300);
    exp_q = '{16'h1413, 16'hFFFF};
    check_words("t6b", base);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/drift_time_capture.md
# drift_time_capture

32-channel drift-time digitizer that sits directly upstream of the event FIFO in the muon-tracker readout. It arms on a scintillator coincidence and timestamps the first rising edge on each drift-tube discriminator line in clk50 cycles. At the end of the window it streams {time, tube name} words plus a trailer to the FIFO writer through a valid/ready handshake. It replaces the per-tube free-running capture plus fixed-case write sequencer with one scanned, back-pressure-aware stage.

## Interface
- WINDOW, 255: acquisition window length in clk50 cycles (1..255).
- HOLDOFF, 11: dead cycles after the trailer before re-arming.
- EMIT_ALL, 0: 1 = emit all 32 channels (time 0 = no hit); 0 = emit hit channels only.
- clk50  in  1  sole clock, 50 MHz.
- CLR_N  in  1  asynchronous active-low reset.
- SCIN_COIN  in  1  async scintillator coincidence.
- TUBE  in  32  async discriminator lines: [7:0]=3A0..7, [15:8]=3B0..7, [23:16]=4A0..7, [31:24]=4B0..7.
- OUT_DATA  out  16  [15:8] drift time, [7:0] tube name.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  consumer accepts (FIFO not full).
- BUSY  out  1  high in any state except IDLE.
- OVERRUN  out  8  saturating count of coincidences dropped while BUSY.

## Operation
- Every async input passes through a 2-flop synchronizer, then a rising-edge detector (registered previous value).
- FSM states: IDLE, ARMED, SCAN, TRAILER, HOLDOFF.
- IDLE: a SCIN_COIN edge moves the FSM to ARMED. Tube edges are ignored.
- ARMED: 8-bit cntr reads 1 in the first ARMED cycle and increments every cycle.
  - On channel i's first edge, hit_time[i] <= cntr and hit[i] <= 1. Later edges on that channel are ignored.
  - A line already high at arm time records no hit until it falls and rises again.
  - In the cycle cntr == WINDOW, edges are still captured, then the FSM moves to SCAN with ptr = 0.
- SCAN handles one channel per cycle, in order 0..31.
  - If hit[ptr] or EMIT_ALL: drive OUT_VALID with {hit_time[ptr], name(ptr)}. Advance ptr on the OUT_VALID && OUT_READY cycle.
  - Otherwise: advance ptr with no valid.
  - After ptr 31 is done, go to TRAILER.
- Name encoding, for channel i = 8·g + k with g ∈ {3A, 3B, 4A, 4B}:
  - [7:5] = k.
  - [4] = 1 for B, 0 for A.
  - [3:0] = 3 for tube-3 groups, 4 for tube-4 groups.
  - Examples: 3A0 = 0x03, 3B7 = 0xF3, 4A2 = 0x44.
- TRAILER: OUT_DATA = 16'hFFFF with OUT_VALID. Accepted on handshake, then HOLDOFF.
- HOLDOFF: count HOLDOFF cycles, clear all hit/hit_time, return to IDLE.
- A SCIN_COIN edge while BUSY is dropped and increments OVERRUN, which saturates at 255.
- Reset values: all outputs 0, OUT_DATA 0, FSM IDLE, hits cleared, OVERRUN 0.
- Reset mid-operation aborts the event immediately. No trailer is emitted.

## Timing
- Input to edge-detect latency: 3 clk50 cycles for both SCIN_COIN and TUBE.
  - Equal latency, so relative drift time is preserved.
  - Absolute offset is 0.
- Resolution is 20 ns. Maximum recordable time is WINDOW.
- A tube edge detected in the same cycle as the SCIN_COIN edge (in IDLE) is not recorded.
- First OUT_VALID appears no earlier than the cycle after the FSM enters SCAN.
- Handshake rules:
  - While OUT_VALID && !OUT_READY, OUT_DATA holds stable and OUT_VALID stays high.
  - With OUT_READY held high, one word per cycle for back-to-back hit channels.
- Minimum event turnaround with OUT_READY = 1: WINDOW + 32 + 1 + HOLDOFF cycles.
- OVERRUN updates 1 cycle after the dropped edge is detected.

## Structure
- Shared package qn_tdc_pkg holds:
  - state enum;
  - TRAILER_WORD = 16'hFFFF;
  - NUM_CH = 32;
  - name-encoding function name(ch) returning 8 bits;
  - synchronizer depth constant (2).
- One sub-module, drift_channel, instantiated 32 times. It contains:
  - synchronizer, edge detect, first-hit latch, and 8-bit time register;
  - inputs: arm, clear, cntr.
- The top contains the FSM, cntr, scan mux, and OVERRUN.

## Test plan
- SCIN_COIN edge, TUBE[0] edge 10 cycles later, TUBE[31] edge 40 cycles later, OUT_READY = 1 → words 16'h0A03, 16'h28F4, 16'hFFFF; BUSY drops after HOLDOFF.
- No tube edges → only 16'hFFFF emitted. With EMIT_ALL = 1 → 32 words with time 0 and names 0x03..0xF4 in order, then the trailer.
- TUBE[5] pulsed twice (at 7 and 20) → single word 16'h07A3. TUBE[6] held high through the arm, then rising at 30 → 16'h1EC3.
- OUT_READY low for 5 cycles while the first word is valid → OUT_DATA stable, no word lost or duplicated, then normal drain.
- Second SCIN_COIN during ARMED, and another during HOLDOFF → OVERRUN = 2, current event unaffected. 300 extra coincidences → OVERRUN = 255.
- CLR_N asserted during SCAN → OUT_VALID 0 the same cycle, BUSY 0, hits cleared; the next coincidence produces a clean event.
